// File: rtl/piso_tx_if.sv
// Bundles the parallel-load request and serial-link outputs of piso_tx.
// The master drives DATA/LOAD; the slave (piso_tx) drives DOUT/VALID/BUSY/DONE.
interface piso_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] DATA;
  logic             LOAD;
  logic             DOUT;
  logic             VALID;
  logic             BUSY;
  logic             DONE;

  modport master (
    output DATA,
    output LOAD,
    input  DOUT,
    input  VALID,
    input  BUSY,
    input  DONE
  );

  modport slave (
    input  DATA,
    input  LOAD,
    output DOUT,
    output VALID,
    output BUSY,
    output DONE
  );
endinterface

// File: rtl/piso_tx.sv
// Parallel-in, serial-out transmitter: sends a WIDTH-bit word MSB-first, each bit held BIT_DIV cycles.
// Define PISO_TX_PARITY_EN to append an even-parity bit after bit 0.
module piso_tx #(
  parameter int WIDTH   = 8,
  parameter int BIT_DIV = 1
) (
  input  logic       clk,
  input  logic       rs,
  piso_tx_if.slave   bus
);

`ifdef PISO_TX_PARITY_EN
  localparam int N_BITS = WIDTH + 1;
`else
  localparam int N_BITS = WIDTH;
`endif
  localparam int CNT_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam int DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               dout_q, dout_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef PISO_TX_PARITY_EN
  logic               parity_q, parity_d;
`endif

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    div_d     = div_q;
    dout_d    = dout_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
`ifdef PISO_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      IDLE: begin
        dout_d    = 1'b0;
        valid_d   = 1'b0;
        busy_d    = 1'b0;
        bit_cnt_d = '0;
        div_d     = '0;
        if (bus.LOAD) begin
          state_d  = SHIFT;
          shreg_d  = bus.DATA;
          dout_d   = bus.DATA[WIDTH-1];
          valid_d  = 1'b1;
          busy_d   = 1'b1;
`ifdef PISO_TX_PARITY_EN
          parity_d = ^bus.DATA;
`endif
        end
      end

      SHIFT: begin
        if (div_q == DIV_W'(BIT_DIV - 1)) begin
          div_d = '0;
          if (bit_cnt_q == CNT_W'(N_BITS - 1)) begin
            // Last bit finished: drop the link and pulse DONE on the same edge.
            state_d   = IDLE;
            bit_cnt_d = '0;
            dout_d    = 1'b0;
            valid_d   = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            shreg_d   = shreg_q << 1;
`ifdef PISO_TX_PARITY_EN
            if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
              dout_d = parity_q;
            end else begin
              dout_d = shreg_q[WIDTH-2];
            end
`else
            dout_d = shreg_q[WIDTH-2];
`endif
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rs) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      div_q     <= '0;
      dout_q    <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef PISO_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      div_q     <= div_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef PISO_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign bus.DOUT  = dout_q;
  assign bus.VALID = valid_q;
  assign bus.BUSY  = busy_q;
  assign bus.DONE  = done_q;

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: one instance with BIT_DIV=1 (sel 0) and one with BIT_DIV=3 (sel 1).
module tb_piso_tx;

  logic clk;
  logic rs;
  int   total;
  int   bad;

  piso_tx_if #(.WIDTH(8)) bus1 ();
  piso_tx_if #(.WIDTH(8)) bus3 ();

  piso_tx #(.WIDTH(8), .BIT_DIV(1)) dut1 (
    .clk (clk),
    .rs  (rs),
    .bus (bus1)
  );

  piso_tx #(.WIDTH(8), .BIT_DIV(3)) dut3 (
    .clk (clk),
    .rs  (rs),
    .bus (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         sel;
    int         div;
    logic [7:0] data;
    logic [7:0] bits;
    logic       par;
  } vec_t;

  vec_t vecs [6];

  // {DOUT, VALID, BUSY, DONE} of the selected instance
  function automatic logic [3:0] outs(input int sel);
    if (sel == 0) return {bus1.DOUT, bus1.VALID, bus1.BUSY, bus1.DONE};
    return {bus3.DOUT, bus3.VALID, bus3.BUSY, bus3.DONE};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int sel, input logic load, input logic [7:0] data);
    if (sel == 0) begin
      bus1.LOAD = load;
      bus1.DATA = data;
    end else begin
      bus3.LOAD = load;
      bus3.DATA = data;
    end
  endtask

  task automatic checkOutput(input string name, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got dout/valid/busy/done=%b required %b", name, got, exp);
    end
  endtask

  // Starts in the first bit cycle, ends sampled in the DONE cycle.
  task automatic checkFrame(input int sel, input logic [7:0] bits, input logic par,
                            input int div, input string name);
    for (int i = 7; i >= 0; i--) begin
      for (int d = 0; d < div; d++) begin
        checkOutput($sformatf("%s_bit%0d_c%0d", name, i, d), outs(sel), {bits[i], 3'b110});
        tick();
      end
    end
`ifdef PISO_TX_PARITY_EN
    for (int d = 0; d < div; d++) begin
      checkOutput($sformatf("%s_par_c%0d", name, d), outs(sel), {par, 3'b110});
      tick();
    end
`else
    if (par !== 1'bx) begin
    end
`endif
    checkOutput({name, "_done"}, outs(sel), 4'b0001);
  endtask

  task automatic runFrame(input vec_t v, input int idx);
    string name;
    name = $sformatf("vec%0d_%h", idx, v.data);
    applyStimulus(v.sel, 1'b1, v.data);
    tick();
    applyStimulus(v.sel, 1'b0, ~v.data);
    checkFrame(v.sel, v.bits, v.par, v.div, name);
    tick();
    checkOutput({name, "_idle"}, outs(v.sel), 4'b0000);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rs    = 1'b0;
    applyStimulus(0, 1'b0, 8'h00);
    applyStimulus(1, 1'b0, 8'h00);

    vecs[0] = '{sel: 0, div: 1, data: 8'hA5, bits: 8'b1010_0101, par: 1'b0};
    vecs[1] = '{sel: 1, div: 3, data: 8'h80, bits: 8'b1000_0000, par: 1'b1};
    vecs[2] = '{sel: 0, div: 1, data: 8'h07, bits: 8'b0000_0111, par: 1'b1};
    vecs[3] = '{sel: 0, div: 1, data: 8'h03, bits: 8'b0000_0011, par: 1'b0};
    vecs[4] = '{sel: 1, div: 3, data: 8'h5B, bits: 8'b0101_1011, par: 1'b1};
    vecs[5] = '{sel: 0, div: 1, data: 8'h3C, bits: 8'b0011_1100, par: 1'b0};

    // Reset held two cycles with LOAD asserted must keep everything low.
    rs = 1'b1;
    applyStimulus(0, 1'b1, 8'hFF);
    applyStimulus(1, 1'b1, 8'hFF);
    for (int c = 0; c < 2; c++) begin
      tick();
      checkOutput($sformatf("reset_c%0d_div1", c), outs(0), 4'b0000);
      checkOutput($sformatf("reset_c%0d_div3", c), outs(1), 4'b0000);
    end
    rs = 1'b0;
    applyStimulus(0, 1'b0, 8'h00);
    applyStimulus(1, 1'b0, 8'h00);
    tick();
    checkOutput("post_reset_idle_div1", outs(0), 4'b0000);
    checkOutput("post_reset_idle_div3", outs(1), 4'b0000);

    foreach (vecs[k]) runFrame(vecs[k], k);

    // LOAD during a frame must not disturb it or start a second one.
    applyStimulus(0, 1'b1, 8'hF0);
    tick();
    applyStimulus(0, 1'b0, 8'hF0);
    for (int i = 7; i >= 0; i--) begin
      checkOutput($sformatf("lockout_bit%0d", i), outs(0), {((i >= 4) ? 1'b1 : 1'b0), 3'b110});
      if (i == 5) applyStimulus(0, 1'b1, 8'h0F);
      if (i == 4) applyStimulus(0, 1'b0, 8'h0F);
      tick();
    end
`ifdef PISO_TX_PARITY_EN
    checkOutput("lockout_par", outs(0), 4'b0110);
    tick();
`endif
    checkOutput("lockout_done", outs(0), 4'b0001);
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput($sformatf("lockout_after_c%0d", c), outs(0), 4'b0000);
    end

    // LOAD held high gives back-to-back frames, then a mid-frame reset.
    applyStimulus(0, 1'b1, 8'h81);
    tick();
    checkFrame(0, 8'b1000_0001, 1'b0, 1, "b2b_f1");
    tick();
    checkFrame(0, 8'b1000_0001, 1'b0, 1, "b2b_f2");
    tick();
    for (int i = 7; i >= 5; i--) begin
      checkOutput($sformatf("b2b_f3_bit%0d", i), outs(0), {((i == 7) ? 1'b1 : 1'b0), 3'b110});
      tick();
    end
    checkOutput("b2b_f3_bit4", outs(0), 4'b0110);
    rs = 1'b1;
    tick();
    checkOutput("abort_reset", outs(0), 4'b0000);
    rs = 1'b0;
    applyStimulus(0, 1'b0, 8'h00);
    for (int c = 0; c < 4; c++) begin
      tick();
      checkOutput($sformatf("abort_no_done_c%0d", c), outs(0), 4'b0000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
